// File: rtl/cpu_test_sequencer.sv
// cpu_test_sequencer: boot/test controller that loads imem and dmem, runs the cpu
// for a set number of cycles, then streams dmem contents back out.
module cpu_test_sequencer #(
    parameter int          CNT_W     = 16,
    parameter logic [63:0] IMEM_BASE = 64'h0,
    parameter logic [63:0] DMEM_BASE = 64'h0
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             start,
    input  logic [CNT_W-1:0] imem_words,
    input  logic [CNT_W-1:0] dmem_words,
    input  logic [CNT_W-1:0] run_cycles,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [63:0]      s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [63:0]      m_data,
    output logic             cpu_enable,
    output logic [63:0]      addr_ext,
    output logic             wen_ext,
    output logic             ren_ext,
    output logic [31:0]      wdata_ext,
    output logic [63:0]      addr_ext_2,
    output logic             wen_ext_2,
    output logic             ren_ext_2,
    output logic [63:0]      wdata_ext_2,
    input  logic [63:0]      rdata_ext_2,
    output logic             busy,
    output logic             done
);
    typedef enum logic [2:0] {IDLE, LOAD_I, LOAD_D, RUN, DUMP_RD, DUMP_WAIT, DUMP_OUT, DONE} state_t;
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    state_t           state, state_nx;
    logic [CNT_W-1:0] n_i, n_d, n_r, idx, cyc;
    logic             idle, s_hs, m_hs, last;
    // First phase after 'from' whose count is non-zero; empty phases are skipped in one step
    function automatic state_t after(input state_t from, input logic [CNT_W-1:0] ni, nd, nr);
        if (from == IDLE && ni != '0) return LOAD_I;
        if ((from == IDLE || from == LOAD_I) && nd != '0) return LOAD_D;
        if (from != RUN && nr != '0) return RUN;
        return nd != '0 ? DUMP_RD : DONE;
    endfunction
    assign idle        = state == IDLE || state == DONE;
    assign s_ready     = state == LOAD_I || state == LOAD_D;
    assign s_hs        = s_valid && s_ready;
    assign m_valid     = state == DUMP_OUT;
    assign m_hs        = m_valid && m_ready;
    assign last        = idx == (state == LOAD_I ? n_i : n_d) - ONE;
    assign cpu_enable  = state == RUN;
    assign busy        = !idle;
    assign done        = state == DONE;
    assign ren_ext     = 1'b0;
    assign wen_ext     = state == LOAD_I && s_valid;
    assign addr_ext    = wen_ext ? IMEM_BASE + (64'(idx) << 2) : '0;
    assign wdata_ext   = wen_ext ? s_data[31:0] : '0;
    assign wen_ext_2   = state == LOAD_D && s_valid;
    assign ren_ext_2   = state == DUMP_RD;
    assign addr_ext_2  = (wen_ext_2 || ren_ext_2) ? DMEM_BASE + (64'(idx) << 3) : '0;
    assign wdata_ext_2 = wen_ext_2 ? s_data : '0;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: state_nx = start ? after(IDLE, imem_words, dmem_words, run_cycles) : state;
            LOAD_I:     state_nx = (s_hs && last) ? after(LOAD_I, n_i, n_d, n_r) : state;
            LOAD_D:     state_nx = (s_hs && last) ? after(LOAD_D, n_i, n_d, n_r) : state;
            RUN:        state_nx = (cyc == n_r - ONE) ? after(RUN, n_i, n_d, n_r) : state;
            DUMP_RD:    state_nx = DUMP_WAIT;
            DUMP_WAIT:  state_nx = DUMP_OUT;
            DUMP_OUT:   state_nx = m_hs ? (last ? DONE : DUMP_RD) : state;
        endcase
    end
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state  <= IDLE;
            n_i    <= '0;
            n_d    <= '0;
            n_r    <= '0;
            idx    <= '0;
            cyc    <= '0;
            m_data <= '0;
        end else begin
            state <= state_nx;
            if (idle && start) begin
                n_i <= imem_words;
                n_d <= dmem_words;
                n_r <= run_cycles;
                idx <= '0;
                cyc <= '0;
            end else if (s_hs || m_hs) begin
                idx <= last ? '0 : idx + ONE;
            end
            if (state == RUN) cyc <= cyc + ONE;
            if (state == DUMP_WAIT) m_data <= rdata_ext_2;
        end
    end
endmodule

// File: tb/tb_cpu_test_sequencer.sv
// tb_cpu_test_sequencer: random-stream bench with memory models and a sequence-level reference.
module tb_cpu_test_sequencer;
    logic        clk = 0, arst = 1, start = 0;
    logic [15:0] imem_words = 0, dmem_words = 0, run_cycles = 0;
    logic        s_valid = 0, s_ready, m_valid, m_ready = 0;
    logic [63:0] s_data = 0, m_data, addr_ext, addr_ext_2, wdata_ext_2, rdata_ext_2;
    logic        cpu_enable, wen_ext, ren_ext, wen_ext_2, ren_ext_2, busy, done;
    logic [31:0] wdata_ext;
    logic [31:0] imem [64];
    logic [63:0] dmem [64];
    int          n_vec = 0, n_err = 0;
    int          en_cnt = 0, en_rise = 0, wi_cnt = 0, wd_cnt = 0, rd_cnt = 0, prot = 0;
    logic        p_en = 0, p_v = 0, p_r = 0;
    logic [63:0] p_d = 0;

    cpu_test_sequencer dut (
        .clk(clk), .arst(arst), .start(start),
        .imem_words(imem_words), .dmem_words(dmem_words), .run_cycles(run_cycles),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .cpu_enable(cpu_enable), .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext),
        .wdata_ext(wdata_ext), .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2),
        .ren_ext_2(ren_ext_2), .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Memories with one-cycle read latency; junk is returned when no read is issued
    always @(posedge clk) begin
        if (wen_ext) imem[addr_ext[7:2]] <= wdata_ext;
        if (wen_ext_2) dmem[addr_ext_2[8:3]] <= wdata_ext_2;
        rdata_ext_2 <= ren_ext_2 ? dmem[addr_ext_2[8:3]] : {$urandom, $urandom};
    end

    // Protocol observers, cumulative over the whole run
    always @(posedge clk) begin
        en_cnt  <= en_cnt + int'(cpu_enable);
        en_rise <= en_rise + int'(cpu_enable && !p_en);
        wi_cnt  <= wi_cnt + int'(wen_ext);
        wd_cnt  <= wd_cnt + int'(wen_ext_2);
        rd_cnt  <= rd_cnt + int'(ren_ext_2);
        prot    <= prot + int'(wen_ext && !(s_valid && s_ready)) + int'(wen_ext_2 && !(s_valid && s_ready))
                 + int'(ren_ext) + int'(cpu_enable && (wen_ext || wen_ext_2 || ren_ext_2))
                 + int'(p_v && !p_r && (!m_valid || m_data !== p_d));
        p_en    <= cpu_enable;
        p_v     <= m_valid;
        p_r     <= m_ready;
        p_d     <= m_data;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // vp < 0 toggles s_valid every other cycle; stall holds m_ready low that many cycles per word
    task automatic run_seq(input int ni, input int nd, input int nr, input int vp, input int rp,
                           input int stall, input bit beef);
        logic [63:0] w[$];
        logic [63:0] got[$];
        int p = 0, wc = 0, cyc = 0;
        int e0 = en_cnt, r0 = en_rise, wi0 = wi_cnt, wd0 = wd_cnt, rd0 = rd_cnt, pr0 = prot;
        bit hs_s, hs_m;
        logic [63:0] md;
        for (int k = 0; k < ni + nd; k++) w.push_back({$urandom, $urandom});
        if (beef) w[ni + 1] = 64'hDEAD_BEEF;
        @(negedge clk);
        imem_words = 16'(ni);
        dmem_words = 16'(nd);
        run_cycles = 16'(nr);
        start = 1;
        @(negedge clk);
        start = 0;
        while (done !== 1'b1 && cyc < 3000) begin
            s_valid = p < w.size() && (vp < 0 ? cyc % 2 == 0 : $urandom_range(99) < vp);
            s_data = s_valid ? w[p] : {$urandom, $urandom};
            if (m_valid) wc++;
            m_ready = wc > stall && $urandom_range(99) < rp;
            #1;
            hs_s = s_valid && s_ready;
            hs_m = m_valid && m_ready;
            md = m_data;
            @(posedge clk);
            if (hs_s) p++;
            if (hs_m) begin
                got.push_back(md);
                wc = 0;
            end
            @(negedge clk);
            cyc++;
        end
        s_valid = 0;
        m_ready = 0;
        check("done", done, 1);
        check("busy_end", busy, 0);
        if (ni + nd + nr == 0) check("zero_latency", cyc, 0);
        check("en_cycles", en_cnt - e0, nr);
        check("en_rises", en_rise - r0, nr != 0);
        check("imem_writes", wi_cnt - wi0, ni);
        check("dmem_writes", wd_cnt - wd0, nd);
        check("dmem_reads", rd_cnt - rd0, nd);
        check("protocol", prot - pr0, 0);
        check("dump_count", got.size(), nd);
        for (int k = 0; k < ni; k++) check("imem_word", imem[k], w[k][31:0]);
        for (int k = 0; k < nd; k++) check("dmem_word", dmem[k], w[ni + k]);
        for (int k = 0; k < nd && k < got.size(); k++) check("dump_word", got[k], w[ni + k]);
        if (beef) check("dump_beef", got.size() > 1 ? got[1] : 64'h0, 64'hDEAD_BEEF);
    endtask

    initial begin
        int wi0;
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_s_ready", s_ready, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_cpu_en", cpu_enable, 0);
        check("rst_addr2", addr_ext_2, 0);
        @(negedge clk);
        arst = 0;
        @(negedge clk);
        imem_words = 8;
        dmem_words = 0;
        run_cycles = 0;
        start = 1;
        @(negedge clk);
        start = 0;
        wi0 = wi_cnt;
        for (int i = 0; i < 3; i++) begin
            s_valid = 1;
            s_data = {$urandom, $urandom};
            @(negedge clk);
        end
        #2 arst = 1;
        #1;
        check("mid_writes", wi_cnt - wi0, 3);
        check("mid_s_ready", s_ready, 0);
        check("mid_wen", wen_ext, 0);
        check("mid_addr", addr_ext, 0);
        check("mid_wdata", wdata_ext, 0);
        check("mid_busy", busy, 0);
        check("mid_done", done, 0);
        @(negedge clk);
        arst = 0;
        s_valid = 0;
        run_seq(8, 0, 0, 100, 100, 0, 0);
        run_seq(4, 2, 10, 100, 100, 0, 0);
        run_seq(6, 3, 5, -1, 100, 0, 0);
        run_seq(2, 3, 1, 100, 100, 5, 0);
        run_seq(0, 0, 0, 100, 100, 0, 0);
        run_seq(3, 2, 0, 100, 100, 0, 1);
        run_seq(0, 3, 0, 60, 70, 0, 0);
        for (int i = 0; i < 8; i++)
            run_seq($urandom_range(12), $urandom_range(12), $urandom_range(20),
                    $urandom_range(30, 100), $urandom_range(30, 100), $urandom_range(3), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
